// File: rtl/cpu_control_seq.sv
// Registered, handshaked decode stage. It splits CALL/RET into two micro-ops, inserts load-use bubbles and handles flush.
// Build with CPU_CONTROL_PERF_EN defined to add the saturating perf_issued/perf_stalls counters.
module cpu_control_seq #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 5,
   parameter int REG_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] in_opcode,
   input  logic [REG_W-1:0]    in_rd,
   input  logic [REG_W-1:0]    in_rs1,
   input  logic [REG_W-1:0]    in_rs2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [13:0]         ctl_flags,
   output logic                ctl_call,
   output logic                ctl_ret,
   output logic [1:0]          ctl_branch_cond,
   output logic [1:0]          ctl_alu_src,
   output logic [ALUOP_W-1:0]  ctl_alu_op,
   output logic [REG_W-1:0]    ctl_rd,
   output logic [REG_W-1:0]    ctl_rs1,
   output logic [REG_W-1:0]    ctl_rs2,
   output logic [15:0]         perf_issued,
   output logic [15:0]         perf_stalls
);

   localparam int F_BRANCH     = 0;
   localparam int F_JREG       = 1;
   localparam int F_PUSH       = 2;
   localparam int F_POP        = 3;
   localparam int F_MEM_TO_REG = 4;
   localparam int F_LOAD_IMM   = 5;
   localparam int F_REG_WR     = 6;
   localparam int F_MEM_WR     = 7;
   localparam int F_MEM_RD     = 8;
   localparam int F_OAM_WR     = 9;
   localparam int F_RD1_EN     = 10;
   localparam int F_RD2_EN     = 11;
   localparam int F_UOP        = 12;
   localparam int F_ILLEGAL    = 13;

   localparam logic [1:0] SRC_RT    = 2'b00;
   localparam logic [1:0] SRC_IMM   = 2'b01;
   localparam logic [1:0] SRC_SHAMT = 2'b10;
   localparam logic [1:0] SRC_NONE  = 2'b11;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);

   typedef enum logic {ST_ISSUE, ST_SEQ2} state_t;

   typedef struct packed {
      logic [13:0]        flags;
      logic               call;
      logic               ret;
      logic [1:0]         cond;
      logic [1:0]         alu_src;
      logic [ALUOP_W-1:0] alu_op;
   } ctl_t;

   function automatic ctl_t idle_word();
      ctl_t w;
      w.flags   = '0;
      w.call    = 1'b0;
      w.ret     = 1'b0;
      w.cond    = 2'b11;
      w.alu_src = SRC_NONE;
      w.alu_op  = ALU_ADD;
      return w;
   endfunction

   // Second half of a CALL (store return address) or RET (pop stack pointer).
   function automatic ctl_t uop1_word(input logic is_ret);
      ctl_t w;
      w = idle_word();
      w.flags[F_UOP] = 1'b1;
      if (is_ret) begin
         w.ret               = 1'b1;
         w.flags[F_REG_WR]   = 1'b1;
         w.alu_src           = SRC_SHAMT;
         w.alu_op            = ALU_ADD;
      end else begin
         w.call              = 1'b1;
         w.flags[F_MEM_WR]   = 1'b1;
      end
      return w;
   endfunction

   state_t            state_q, state_d;
   ctl_t              word_q, word_d;
   logic              valid_q, valid_d;
   logic              seq_ret_q;
   logic              idx_load;
   logic [REG_W-1:0]  rd_q, rs1_q, rs2_q;

   ctl_t              dec;
   logic              dec_seq;
   logic              dec_ret;
   logic              op_upper;
   logic [5:0]        op;
   logic              load_en;
   logic              hazard;
   logic              accept;

   assign op = in_opcode[5:0];

   if (OPCODE_W > 6) begin : g_wide_op
      assign op_upper = |in_opcode[OPCODE_W-1:6];
   end else begin : g_narrow_op
      assign op_upper = 1'b0;
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      dec     = idle_word();
      dec_seq = 1'b0;
      dec_ret = 1'b0;
      if (op_upper) begin
         dec.flags[F_ILLEGAL] = 1'b1;
      end else if (op != 6'b111111) begin
         if (op[5]) begin
            dec.flags[F_REG_WR] = 1'b1;
            dec.flags[F_RD1_EN] = 1'b1;
            dec.alu_op          = ALUOP_W'(op[4:0]);
            if (op[1:0] == 2'b01) begin
               dec.alu_src = SRC_IMM;
            end else if (op[2:1] == 2'b11) begin
               dec.alu_src = SRC_SHAMT;
            end else begin
               dec.alu_src         = SRC_RT;
               dec.flags[F_RD2_EN] = 1'b1;
            end
         end else if (op[4]) begin
            dec.flags[F_OAM_WR] = 1'b1;
            dec.flags[F_RD1_EN] = 1'b1;
            dec.flags[F_RD2_EN] = 1'b1;
         end else if (!op[3]) begin
            if (!op[2]) begin
               dec.flags[F_BRANCH] = 1'b1;
               dec.flags[F_RD1_EN] = 1'b1;
               dec.flags[F_RD2_EN] = 1'b1;
               dec.cond            = op[1:0];
               dec.alu_op          = ALU_ADD;
               dec.alu_src         = SRC_IMM;
            end else if (op[1]) begin
               dec.flags[F_JREG]   = 1'b1;
               dec.flags[F_RD1_EN] = 1'b1;
            end else begin
               dec_seq = 1'b1;
               dec_ret = op[0];
               if (op[0]) begin
                  dec.flags[F_MEM_RD] = 1'b1;
               end else begin
                  dec.flags[F_REG_WR] = 1'b1;
                  dec.alu_op          = ALU_SUB;
                  dec.alu_src         = SRC_SHAMT;
               end
            end
         end else begin
            case (op[2:0])
               3'b000: begin
                  dec.flags[F_MEM_RD]     = 1'b1;
                  dec.flags[F_MEM_TO_REG] = 1'b1;
                  dec.flags[F_REG_WR]     = 1'b1;
                  dec.flags[F_RD1_EN]     = 1'b1;
                  dec.alu_src             = SRC_IMM;
               end
               3'b001: begin
                  dec.flags[F_LOAD_IMM] = 1'b1;
                  dec.flags[F_REG_WR]   = 1'b1;
                  dec.alu_src           = SRC_IMM;
               end
               3'b010: begin
                  dec.flags[F_POP]        = 1'b1;
                  dec.flags[F_MEM_RD]     = 1'b1;
                  dec.flags[F_MEM_TO_REG] = 1'b1;
                  dec.flags[F_REG_WR]     = 1'b1;
                  dec.alu_src             = SRC_SHAMT;
               end
               3'b100: begin
                  dec.flags[F_MEM_WR] = 1'b1;
                  dec.flags[F_RD1_EN] = 1'b1;
                  dec.flags[F_RD2_EN] = 1'b1;
                  dec.alu_src         = SRC_IMM;
               end
               3'b110: begin
                  dec.flags[F_PUSH]   = 1'b1;
                  dec.flags[F_MEM_WR] = 1'b1;
                  dec.flags[F_REG_WR] = 1'b1;
                  dec.flags[F_RD1_EN] = 1'b1;
                  dec.alu_op          = ALU_SUB;
                  dec.alu_src         = SRC_SHAMT;
               end
               default: dec = idle_word();
            endcase
         end
      end
   end

   // A held load (LW, POP, RET uop0) blocks any incoming reader of its destination; r0 is never a real dependency.
   assign load_en  = !valid_q || out_ready;
   assign hazard   = valid_q && word_q.flags[F_MEM_RD] && (rd_q != '0) &&
                     ((dec.flags[F_RD1_EN] && (in_rs1 == rd_q)) ||
                      (dec.flags[F_RD2_EN] && (in_rs2 == rd_q)));
   assign in_ready = (state_q == ST_ISSUE) && load_en && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ISSUE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_ISSUE;
      end else if (state_q == ST_SEQ2) begin
         if (load_en) begin
            state_d = ST_ISSUE;
         end
      end else if (accept && dec_seq) begin
         state_d = ST_SEQ2;
      end
   end

   always_comb begin
      word_d   = word_q;
      valid_d  = valid_q;
      idx_load = 1'b0;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load_en) begin
         if (state_q == ST_SEQ2) begin
            valid_d = 1'b1;
            word_d  = uop1_word(seq_ret_q);
         end else if (accept) begin
            valid_d  = 1'b1;
            word_d   = dec;
            idx_load = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // NOTE: the output word is a handful of flops, so all of it is reset, giving ID/EX known idle values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         word_q    <= idle_word();
         seq_ret_q <= 1'b0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         if (idx_load) begin
            seq_ret_q <= dec_ret;
            rd_q      <= in_rd;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
         end
      end
   end

   assign out_valid       = valid_q;
   assign ctl_flags       = word_q.flags;
   assign ctl_call        = word_q.call;
   assign ctl_ret         = word_q.ret;
   assign ctl_branch_cond = word_q.cond;
   assign ctl_alu_src     = word_q.alu_src;
   assign ctl_alu_op      = word_q.alu_op;
   assign ctl_rd          = rd_q;
   assign ctl_rs1         = rs1_q;
   assign ctl_rs2         = rs2_q;

`ifdef CPU_CONTROL_PERF_EN
   logic [15:0] issued_q;
   logic [15:0] stalls_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         issued_q <= 16'd0;
         stalls_q <= 16'd0;
      end else begin
         if (valid_q && out_ready && (issued_q != 16'hFFFF)) begin
            issued_q <= issued_q + 16'd1;
         end
         if (in_valid && !in_ready && (stalls_q != 16'hFFFF)) begin
            stalls_q <= stalls_q + 16'd1;
         end
      end
   end

   assign perf_issued = issued_q;
   assign perf_stalls = stalls_q;
`else
   assign perf_issued = 16'd0;
   assign perf_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_control_seq.sv
// Scoreboard bench for cpu_control_seq: directed test-plan cases, then random traffic against a class-level decode model.
module tb_cpu_control_seq;

   localparam int F_BR = 0, F_JR = 1, F_PUSH = 2, F_POP = 3, F_M2R = 4, F_LI = 5, F_RWR = 6;
   localparam int F_MWR = 7, F_MRD = 8, F_OAM = 9, F_RD1 = 10, F_RD2 = 11, F_UOP = 12, F_ILL = 13;

   typedef struct packed {
      logic [13:0] flags;
      logic        call;
      logic        ret;
      logic [1:0]  cond;
      logic [1:0]  src;
      logic [4:0]  alu_op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
   } word_t;

   typedef enum {C_ILL, C_NOP, C_ALU, C_BR, C_JR, C_CALL, C_RET, C_LW, C_LI, C_POP, C_SW, C_PUSH, C_OAM} cls_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_opcode = '0;
   logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [13:0] ctl_flags;
   logic        ctl_call, ctl_ret;
   logic [1:0]  ctl_branch_cond, ctl_alu_src;
   logic [4:0]  ctl_alu_op;
   logic [3:0]  ctl_rd, ctl_rs1, ctl_rs2;
   logic [15:0] perf_issued, perf_stalls;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  in_opcode8 = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [13:0] flags8;
   logic        call8, ret8;
   logic [1:0]  cond8, src8;
   logic [4:0]  alu_op8;
   logic [3:0]  rd8, rs18, rs28;
   logic [15:0] issued8, stalls8;

   int total = 0;
   int bad = 0;
   int n_hs = 0;
   int n_stall = 0;
   word_t exp_q[$];

   always #5 clk = ~clk;

   cpu_control_seq dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready), .ctl_flags(ctl_flags),
      .ctl_call(ctl_call), .ctl_ret(ctl_ret), .ctl_branch_cond(ctl_branch_cond),
      .ctl_alu_src(ctl_alu_src), .ctl_alu_op(ctl_alu_op), .ctl_rd(ctl_rd),
      .ctl_rs1(ctl_rs1), .ctl_rs2(ctl_rs2), .perf_issued(perf_issued), .perf_stalls(perf_stalls)
   );

   cpu_control_seq #(.OPCODE_W(8)) dut8 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_opcode(in_opcode8), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid8), .out_ready(out_ready8), .ctl_flags(flags8),
      .ctl_call(call8), .ctl_ret(ret8), .ctl_branch_cond(cond8),
      .ctl_alu_src(src8), .ctl_alu_op(alu_op8), .ctl_rd(rd8),
      .ctl_rs1(rs18), .ctl_rs2(rs28), .perf_issued(issued8), .perf_stalls(stalls8)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic cls_t classify(input logic [5:0] op, input bit upper);
      if (upper) return C_ILL;
      if (op == 6'h3F) return C_NOP;
      if (op[5]) return C_ALU;
      if (op[4]) return C_OAM;
      if (!op[3]) begin
         if (!op[2]) return C_BR;
         if (op[1]) return C_JR;
         return op[0] ? C_RET : C_CALL;
      end
      case (op[2:0])
         3'd0: return C_LW;
         3'd1: return C_LI;
         3'd2: return C_POP;
         3'd4: return C_SW;
         3'd6: return C_PUSH;
         default: return C_NOP;
      endcase
   endfunction

   // Expected control word(s) for one instruction, built from its class; CALL/RET yield two.
   task automatic model_words(input logic [5:0] op, input bit upper, input logic [3:0] rd, rs1, rs2,
                              output word_t w0, output word_t w1, output bit two);
      cls_t  c;
      word_t w;
      c = classify(op, upper);
      w = '0;
      w.cond = 2'b11;
      w.src  = 2'b11;
      w.rd = rd; w.rs1 = rs1; w.rs2 = rs2;
      two = 1'b0;
      w1  = w;
      case (c)
         C_ILL:  w.flags[F_ILL] = 1'b1;
         C_ALU: begin
            w.flags[F_RWR] = 1'b1; w.flags[F_RD1] = 1'b1; w.alu_op = op[4:0];
            if (op[1:0] == 2'b01)      w.src = 2'b01;
            else if (op[2:1] == 2'b11) w.src = 2'b10;
            else begin w.src = 2'b00; w.flags[F_RD2] = 1'b1; end
         end
         C_BR:   begin w.flags[F_BR] = 1'b1; w.flags[F_RD1] = 1'b1; w.flags[F_RD2] = 1'b1; w.cond = op[1:0]; w.src = 2'b01; end
         C_JR:   begin w.flags[F_JR] = 1'b1; w.flags[F_RD1] = 1'b1; end
         C_CALL: begin
            two = 1'b1;
            w.flags[F_RWR] = 1'b1; w.alu_op = 5'd2; w.src = 2'b10;
            w1.flags[F_MWR] = 1'b1; w1.flags[F_UOP] = 1'b1; w1.call = 1'b1;
         end
         C_RET: begin
            two = 1'b1;
            w.flags[F_MRD] = 1'b1;
            w1.flags[F_RWR] = 1'b1; w1.flags[F_UOP] = 1'b1; w1.ret = 1'b1; w1.src = 2'b10;
         end
         C_LW:   begin w.flags[F_MRD] = 1'b1; w.flags[F_M2R] = 1'b1; w.flags[F_RWR] = 1'b1; w.flags[F_RD1] = 1'b1; w.src = 2'b01; end
         C_LI:   begin w.flags[F_LI] = 1'b1; w.flags[F_RWR] = 1'b1; w.src = 2'b01; end
         C_POP:  begin w.flags[F_POP] = 1'b1; w.flags[F_MRD] = 1'b1; w.flags[F_M2R] = 1'b1; w.flags[F_RWR] = 1'b1; w.src = 2'b10; end
         C_SW:   begin w.flags[F_MWR] = 1'b1; w.flags[F_RD1] = 1'b1; w.flags[F_RD2] = 1'b1; w.src = 2'b01; end
         C_PUSH: begin w.flags[F_PUSH] = 1'b1; w.flags[F_MWR] = 1'b1; w.flags[F_RWR] = 1'b1; w.flags[F_RD1] = 1'b1; w.alu_op = 5'd2; w.src = 2'b10; end
         C_OAM:  begin w.flags[F_OAM] = 1'b1; w.flags[F_RD1] = 1'b1; w.flags[F_RD2] = 1'b1; end
         default: ;
      endcase
      w0 = w;
   endtask

   function automatic word_t dut_word();
      return {ctl_flags, ctl_call, ctl_ret, ctl_branch_cond, ctl_alu_src, ctl_alu_op, ctl_rd, ctl_rs1, ctl_rs2};
   endfunction

   // Scoreboard monitor: pop on every handshake, drop pending words on flush, push on every accept.
   always @(negedge clk) begin
      word_t w0, w1, e;
      bit    two;
      if (rst) begin
         exp_q.delete();
         n_hs    = 0;
         n_stall = 0;
      end else begin
         if (out_valid && out_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got word %0h, expected no word", dut_word());
            end else begin
               e = exp_q.pop_front();
               check("sb_word", dut_word(), e);
            end
         end
         if (flush) begin
            check("flush_in_ready", in_ready, 1'b0);
            exp_q.delete();
         end
         if (in_valid && !in_ready) n_stall++;
         if (in_valid && in_ready) begin
            model_words(in_opcode, 1'b0, in_rd, in_rs1, in_rs2, w0, w1, two);
            exp_q.push_back(w0);
            if (two) exp_q.push_back(w1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [3:0] rd, rs1, rs2);
      in_valid  = 1'b1;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [5:0]  ops[15];
      word_t       beq_w, dummy;
      bit          two;
      logic [15:0] stalls0;

      ops = '{6'b100000, 6'b100001, 6'b100110, 6'b000000, 6'b000011, 6'b000110, 6'b000100,
              6'b000101, 6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001110, 6'b010000, 6'b111111};

      repeat (3) step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_flags", ctl_flags, 14'h0);
      check("rst_call_ret", {ctl_call, ctl_ret}, 2'b00);
      check("rst_cond_src", {ctl_branch_cond, ctl_alu_src}, 4'b1111);
      check("rst_alu_op_idx", {ctl_alu_op, ctl_rd, ctl_rs1, ctl_rs2}, 17'h0);
      check("rst_perf", {perf_issued, perf_stalls}, 32'h0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      // ADD: one-cycle latency, register-register form
      drive(6'b100000, 4'd5, 4'd1, 4'd2);
      step();
      check("add_valid", out_valid, 1'b1);
      check("add_rwr_rd1_rd2", {ctl_flags[F_RWR], ctl_flags[F_RD1], ctl_flags[F_RD2]}, 3'b111);
      check("add_src_op", {ctl_alu_src, ctl_alu_op}, 7'h0);
      check("add_rd", ctl_rd, 4'd5);
      idle();
      step();
      check("add_drained", out_valid, 1'b0);

      // CALL: two consecutive micro-ops, input blocked in between
      drive(6'b000100, 4'd1, 4'd0, 4'd0);
      step();
      check("call_u0", {ctl_alu_op, ctl_flags[F_RWR], ctl_call, ctl_flags[F_UOP]}, {5'd2, 3'b100});
      drive(6'b100000, 4'd7, 4'd1, 4'd2);
      #1;
      check("call_seq2_in_ready", in_ready, 1'b0);
      step();
      check("call_u1", {out_valid, ctl_flags[F_MWR], ctl_call, ctl_flags[F_UOP]}, 4'b1111);
      check("call_u1_in_ready", in_ready, 1'b1);
      step();
      check("after_call_rd", {out_valid, ctl_rd}, {1'b1, 4'd7});
      idle();
      step();

      // Load-use: exactly one bubble, also through rs2; r0 and a disabled source never stall
      drive(6'b001000, 4'd3, 4'd7, 4'd0);
      step();
      drive(6'b100000, 4'd4, 4'd3, 4'd9);
      #1;
      check("hz_in_ready", in_ready, 1'b0);
      step();
      check("hz_bubble", out_valid, 1'b0);
      check("hz_release", in_ready, 1'b1);
      step();
      check("hz_issue", {out_valid, ctl_rd}, {1'b1, 4'd4});
      drive(6'b001000, 4'd0, 4'd7, 4'd0);
      step();
      drive(6'b100000, 4'd4, 4'd0, 4'd0);
      #1;
      check("hz_r0_in_ready", in_ready, 1'b1);
      step();
      check("hz_r0_issue", {out_valid, ctl_rd}, {1'b1, 4'd4});
      drive(6'b001000, 4'd2, 4'd7, 4'd0);
      step();
      drive(6'b001100, 4'd0, 4'd5, 4'd2);
      #1;
      check("hz_rs2_in_ready", in_ready, 1'b0);
      step();
      check("hz_rs2_release", in_ready, 1'b1);
      drive(6'b001000, 4'd2, 4'd7, 4'd0);
      step();
      drive(6'b100001, 4'd1, 4'd5, 4'd2);
      #1;
      check("hz_imm_no_stall", in_ready, 1'b1);
      step();
      idle();
      step();
      step();

      // BEQ held under backpressure for four cycles
      model_words(6'b000000, 1'b0, 4'd2, 4'd1, 4'd3, beq_w, dummy, two);
      out_ready = 1'b0;
      drive(6'b000000, 4'd2, 4'd1, 4'd3);
      step();
      stalls0 = perf_stalls;
      for (int i = 0; i < 4; i++) begin
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_word", {out_valid, dut_word()}, {1'b1, beq_w});
         check("stall_br_cond", {ctl_flags[F_BR], ctl_branch_cond}, 3'b100);
         step();
      end
`ifdef CPU_CONTROL_PERF_EN
      check("stall_count", perf_stalls - stalls0, 16'd4);
`else
      check("stall_count_off", {stalls0, perf_stalls, perf_issued}, 48'h0);
`endif
      idle();
      out_ready = 1'b1;
      step();
      check("stall_drained", out_valid, 1'b0);

      // Flush during RET sequence: no ret micro-op escapes
      drive(6'b000101, 4'd6, 4'd0, 4'd0);
      step();
      check("ret_u0", {ctl_flags[F_MRD], ctl_ret, ctl_flags[F_UOP]}, 3'b100);
      idle();
      flush = 1'b1;
      #1;
      check("flush_blocks", in_ready, 1'b0);
      step();
      check("flush_kill", out_valid, 1'b0);
      flush = 1'b0;
      #1;
      check("flush_ready_after", in_ready, 1'b1);
      step();
      check("flush_no_ret", {out_valid, ctl_ret}, 2'b00);

      // Reset in the middle of a CALL sequence
      drive(6'b000100, 4'd1, 4'd0, 4'd0);
      step();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_seq", {out_valid, ctl_call, ctl_flags}, 16'h0);
      #1;
      check("rst_mid_ready", in_ready, 1'b1);
      step();
      check("rst_mid_no_u1", out_valid, 1'b0);

      // Wide opcode: any bit above [5] makes the instruction illegal
      in_valid8  = 1'b1;
      in_opcode8 = 8'h40;
      #1;
      check("w8_in_ready", in_ready8, 1'b1);
      step();
      check("w8_illegal", {out_valid8, flags8}, {1'b1, 14'h2000});
      check("w8_illegal_rest", {call8, ret8, cond8, src8}, 6'b001111);
      in_opcode8 = 8'h20;
      step();
      check("w8_legal_alu", {out_valid8, flags8[F_ILL], flags8[F_RWR]}, 3'b101);
      in_valid8 = 1'b0;
      step();

      // Random traffic, with one reset in the middle
      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         in_opcode = ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 14)] : 6'($urandom);
         in_rd     = 4'($urandom_range(0, 3));
         in_rs1    = 4'($urandom_range(0, 3));
         in_rs2    = 4'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 99) < 70);
         flush     = ($urandom_range(0, 99) < 3);
         rst       = (cyc == 1500);
         step();
      end
      rst       = 1'b0;
      flush     = 1'b0;
      idle();
      out_ready = 1'b1;
      repeat (5) step();
      check("sb_drained", exp_q.size(), 0);
      check("drained_valid", out_valid, 1'b0);
`ifdef CPU_CONTROL_PERF_EN
      check("perf_issued", perf_issued, n_hs);
      check("perf_stalls", perf_stalls, n_stall);
`else
      check("perf_off", {perf_issued, perf_stalls}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_control_seq.md
Name: cpu_control_seq

Overview:
- Registered, handshaked instruction-decode stage between IF/ID and ID/EX.
- Successor to the combinational control decoder: same 6-bit opcode map, plus parameterised field widths and a valid/ready pipeline interface.
- Adds a micro-sequencer that splits CALL/RET into two micro-ops, load-use hazard bubbling, and flush handling.

Parameters:
- OPCODE_W, 6: opcode width; bits above [5] must be zero, otherwise the instruction is illegal.
- ALUOP_W, 5: ALU operation field width; ≥5, zero-extended.
- REG_W, 4: register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill held output and in-flight sequence (taken branch)
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_opcode  in  OPCODE_W  opcode
- in_rd  in  REG_W  destination index
- in_rs1  in  REG_W  source 1 index
- in_rs2  in  REG_W  source 2 index
- out_valid  out  1  control word valid
- out_ready  in  1  ID/EX consumes the word when out_valid && out_ready
- ctl_flags  out  14  {illegal,uop,rd2_en,rd1_en,oam_wr,mem_rd,mem_wr,reg_wr,load_imm,mem_to_reg,pop,push,jreg,branch}, MSB..LSB
- ctl_call  out  1  call marker
- ctl_ret  out  1  return marker
- ctl_branch_cond  out  2  branch condition
- ctl_alu_src  out  2  00 rt, 01 imm, 10 shamt/±1, 11 none
- ctl_alu_op  out  ALUOP_W  ALU operation
- ctl_rd, ctl_rs1, ctl_rs2  out  REG_W  registered indices
- perf_issued  out  16  issued control-word count (see Optional Feature)
- perf_stalls  out  16  stall-cycle count (see Optional Feature)

Behaviour:
- Reset values: out_valid=0; every ctl_* = 0 except branch_cond=11 and alu_src=11; state=ISSUE; perf counters=0.
- Output register: loads when (!out_valid || out_ready); otherwise holds every field stable. in_ready = state==ISSUE && (!out_valid || out_ready) && !hazard.
- Latency: 1 cycle from accept to out_valid.
- Decode, class by opcode:
  - all-ones: NOP; out_valid=1 with all enables 0.
  - [5]=1: ALU; alu_op=opcode[4:0]; reg_wr=1; alu_src=01 if [1:0]=x1 with [1]=0, 10 if [1]=1 and [2]=1, else 00.
  - [5:3]=000, [2]=0: branch; branch=1; cond=[1:0]; alu_op=ADD (0); alu_src=01.
  - [5:3]=000, [2:1]=11: jreg=1; rd1_en=1.
  - [5:3]=000, [2:1]=10: CALL ([0]=0) or RET ([0]=1), sequenced as below.
  - [5:4]=00: memory ops. LW [2:0]=000, LI 001, POP 010 (alu_src=10), SW 100, PUSH 110 (alu_op=SUB=2, reg_wr=1, push=1).
  - [4]=1: OAM write; rd1_en=rd2_en=1.
  - else: audio, decoded as NOP.
- Micro-sequencer, states ISSUE, SEQ2:
  - CALL: uop0 = SP decrement (alu_op=2, alu_src=10, reg_wr=1, call=0). uop1 = mem_wr=1, call=1, uop=1.
  - RET: uop0 = mem_rd=1 at SP, ret=0. uop1 = SP increment (alu_op=0, reg_wr=1), ret=1, uop=1.
  - ISSUE→SEQ2 when uop0 loads; SEQ2→ISSUE when uop1 loads. in_ready=0 throughout SEQ2. Indices stay latched.
- Hazard: asserted when the held word is valid with mem_rd=1 and reg_wr-path load (LW/POP/RET-uop0), and ctl_rd matches an enabled source of in_opcode (rs1 if that source reads rs1, rs2 likewise).
  - While hazard and out_ready: a bubble loads (out_valid=0) and the instruction waits exactly one cycle.
  - rd index 0 never hazards.
- Illegal: OPCODE_W>6 with any upper bit set → illegal=1, all other enables 0, out_valid=1.
- Flush: priority below rst, above all else. Next cycle out_valid=0, state=ISSUE; an accept coincident with flush is discarded (in_ready forced 0).
- Reset mid-sequence: abandons SEQ2 with no partial uop1.

Optional Feature:
- Macro CPU_CONTROL_PERF_EN.
- Defined: perf_issued increments on each out_valid && out_ready. perf_stalls increments each cycle in_valid && !in_ready. Both saturate at 16'hFFFF and clear on rst.
- Undefined: both ports tied to 0 and no counter flops exist.

Test Plan:
- ADD opcode 100000, out_ready=1 → next cycle out_valid=1, reg_wr=1, alu_src=00, alu_op=0, rd1_en=rd2_en=1.
- CALL 000100 → two consecutive words: (alu_op=2, reg_wr=1, call=0, uop=0) then (mem_wr=1, call=1, uop=1); in_ready=0 in between.
- LW rd=3, then ADD rs1=3 → one bubble cycle, ADD issues on cycle 3. With rd=0 → no bubble.
- out_ready held 0 for 4 cycles with BEQ (000000) held → word stable, branch=1, cond=00; perf_stalls=4 with macro defined.
- Flush asserted during SEQ2 of RET → out_valid=0 next cycle, no ret=1 emitted, in_ready=1 the following cycle.
- OPCODE_W=8, opcode 0x40 → illegal=1, reg_wr=mem_wr=0.
